// File: rtl/sextium_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single sextium memory port.
// Port A (core) and port B (DMA/loader) share one read/write strobe pair and a bidirectional data bus.
module sextium_mem_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] addr_bus,
  inout  wire  [DATA_W-1:0] mem_bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic       GNT_A    = 1'b0;
  localparam logic       GNT_B    = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_gnt;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_any_req;
  logic              w_pick_b;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_any_req = a_req | b_req;
    w_pick_b  = GNT_A;
    case ({a_req, b_req})
      2'b10:   w_pick_b = GNT_A;
      2'b01:   w_pick_b = GNT_B;
      2'b11:   w_pick_b = ~r_last;
      default: w_pick_b = GNT_A;
    endcase
    if (w_pick_b == GNT_B) begin
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end else begin
      w_sel_we    = a_we;
      w_sel_addr  = a_addr;
      w_sel_wdata = a_wdata;
    end
  end

  // Access sequencer: grant latches the request, strobes run for ACCESS_CYCLES, then one ack cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_gnt       <= GNT_A;
      r_last      <= GNT_B;
      r_we        <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= {DATA_W{1'b0}};
      r_b_rdata   <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          if (w_any_req) begin
            r_gnt       <= w_pick_b;
            r_last      <= w_pick_b;
            r_we        <= w_sel_we;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_cnt       <= CNT_INIT;
            r_mem_read  <= ~w_sel_we;
            r_mem_write <= w_sel_we;
            r_state     <= S_ACCESS;
          end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            // Read data is taken on the same edge that ends the strobe.
            if (!r_we) begin
              if (r_gnt == GNT_B) begin
                r_b_rdata <= mem_bus;
              end else begin
                r_a_rdata <= mem_bus;
              end
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_a_ack     <= (r_gnt == GNT_A);
            r_b_ack     <= (r_gnt == GNT_B);
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_a_ack     <= 1'b0;
          r_b_ack     <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_a_ack     <= 1'b0;
          r_b_ack     <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign addr_bus  = r_addr;
  assign mem_bus   = r_mem_write ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: doc/sextium_mem_arbiter.md
Name: sextium_mem_arbiter

Overview:
- Shares the single 16-bit simulated/physical memory port between two requesters.
- Port A is the sextium_core fetch/load/store path. Port B is a secondary master, such as a DMA or program loader.
- Round-robin arbitration with a per-port req/ack handshake. Drives mem_read/mem_write/addr_bus and the bidirectional mem_bus toward the memory.
- Sits between the requesters and the memory model in the top level and testbench.

Parameters:
ACCESS_CYCLES, 1, number of clock cycles the memory strobe is held per access (1..15)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
a_req  input  1  port A access request, level, held until a_ack
a_we  input  1  port A write enable (1 = write, 0 = read)
a_addr  input  ADDR_W  port A address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  DATA_W  port A read data, valid when a_ack=1 and held until next port A read completes
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
addr_bus  output  ADDR_W  memory address
mem_bus  inout  DATA_W  memory data; driven by arbiter only while mem_write=1, else high-Z

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_read=mem_write=0; addr_bus=0; mem_bus high-Z.
  - a_ack=b_ack=0; a_rdata=b_rdata=0.
  - last_grant=B, so A wins the first tie.
- Reset asserted mid-access aborts the access immediately: strobes drop and no ack is issued. Requesters must re-request after reset releases.
- FSM states:
  - IDLE: if neither req, stay. If exactly one req, grant it. If both, grant the port not equal to last_grant. On grant, latch the winner's we/addr/wdata into internal registers, set last_grant, load cnt=ACCESS_CYCLES-1, go to ACCESS.
  - ACCESS: mem_read=~we_l or mem_write=we_l; addr_bus=addr_l; mem_bus=wdata_l when writing. Decrement cnt each cycle. When cnt=0, capture mem_bus into rdata of the granted port (reads only) at that rising edge, drop strobes, go to DONE.
  - DONE: the granted port's ack=1 for exactly this cycle; strobes 0; go to IDLE.
- Outputs are registered, with no combinational path from req to strobes.
- Latency: req sampled high at edge N -> strobes asserted from edge N to edge N+ACCESS_CYCLES -> ack high for cycle N+ACCESS_CYCLES+1.
  - Uncontended req-to-ack is ACCESS_CYCLES+2 edges.
  - Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- Handshake rules:
  - A requester keeps req, we, addr and wdata stable until it samples ack=1, then drops req on the same edge.
  - req still high in the IDLE cycle after ack counts as a new request.
  - The arbiter does not rely on inputs staying stable after grant, because they are latched.
- Only one ack is high in any cycle, and never both strobes at once.
- Round-robin fairness: with both ports requesting continuously, grants alternate strictly A, B, A, B.
- A write leaves the port's rdata register unchanged.
- A request arriving during ACCESS or DONE of the other port waits. It is served at the next IDLE, ahead of a re-request from the just-served port.
- addr_bus holds its last value in IDLE and DONE; it returns to 0 only on reset.

Test Plan:
- Reset: hold reset=0 for 3 cycles with a_req=1 -> all strobes 0, mem_bus Z, no ack. After reset=1, A is granted within 1 cycle.
- Single read, ACCESS_CYCLES=1: memory word 0x0010=0xBEEF; a_req, a_we=0, a_addr=0x0010 -> mem_read for 1 cycle with addr_bus=0x0010; a_ack on the next cycle with a_rdata=0xBEEF; total 3 edges req-to-ack.
- Write then read by B: b_we=1, b_addr=0x0200, b_wdata=0x1234 -> mem_write 1 cycle with mem_bus=0x1234. A subsequent B read of 0x0200 returns 0x1234, and a_rdata is unchanged.
- Simultaneous requests, held for 4 transactions each -> grant order A, B, A, B; acks never overlap; the mem_read/mem_write sequence matches.
- ACCESS_CYCLES=3: a read holds mem_read for 3 cycles; a_ack arrives 5 edges after req.
- Reset pulse during ACCESS of a B write -> mem_write drops asynchronously and b_ack never fires. After release, a re-issued B write completes normally.
